// File: rtl/e203_gpio_pkg.sv
// Shared limits and helpers for the E203 GPIO pad bank.
package e203_gpio_pkg;

    localparam int CH_MAX    = 64;
    localparam int SYNC_MIN  = 2;
    localparam int SYNC_MAX  = 4;
    localparam int DEB_W_MAX = 24;

    // Width of the warm-up counter. It must hold the terminal count sync_stages+1.
    function automatic int warm_cnt_w(input int sync_stages);
        return $clog2(sync_stages + 2);
    endfunction

endpackage

// File: rtl/e203_gpio_chan.sv
// One GPIO input channel.
// It contains the synchroniser, the debounce filter, edge detection and a sticky pending bit.
module e203_gpio_chan
    import e203_gpio_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             warm,
    input  logic             pad,
    input  logic             deb_en,
    input  logic [DEB_W-1:0] deb_limit,
    input  logic             rise_en,
    input  logic             fall_en,
    input  logic             irq_clr,
    output logic             in_val,
    output logic             irq_pend
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s;
    logic                   f;
    logic                   f_nxt;
    logic [DEB_W-1:0]       c;
    logic [DEB_W-1:0]       c_nxt;
    logic                   rise;
    logic                   fall;
    logic                   pend;

    assign s = sync_p0[SYNC_STAGES-1];

    // Shift the raw pad level through the metastability chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pad};
        end
    end

    // Filter decision.
    // During warm-up or bypass the filter follows s directly.
    // Otherwise s must differ from f for deb_limit+1 cycles before f takes it.
    always_comb begin
        f_nxt = f;
        c_nxt = '0;
        if (!warm || !deb_en) begin
            f_nxt = s;
        end else if (s != f) begin
            if (c >= deb_limit) begin
                f_nxt = s;
            end else begin
                c_nxt = c + DEB_W'(1);
            end
        end
    end

    // An event is only recognised once the bank has warmed up.
    assign rise = warm & ~f &  f_nxt & rise_en;
    assign fall = warm &  f & ~f_nxt & fall_en;

    // Filter state and sticky pending bit. A set beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f    <= 1'b0;
            c    <= '0;
            pend <= 1'b0;
        end else begin
            f    <= f_nxt;
            c    <= c_nxt;
            pend <= (pend & ~irq_clr) | rise | fall;
        end
    end

    assign in_val   = f;
    assign irq_pend = pend;

endmodule

// File: rtl/e203_gpio_pad_bank.sv
// GPIO pad bank.
// It registers the output drive and holds the bank-wide warm-up counter.
// It also instantiates one e203_gpio_chan per channel.
module e203_gpio_pad_bank
    import e203_gpio_pkg::*;
#(
    parameter int CH_NUM      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] pad_i_ival,
    output logic [CH_NUM-1:0] pad_o_oval,
    output logic [CH_NUM-1:0] pad_o_oe,
    input  logic [CH_NUM-1:0] cfg_out_val,
    input  logic [CH_NUM-1:0] cfg_out_en,
    input  logic [CH_NUM-1:0] cfg_deb_en,
    input  logic [DEB_W-1:0]  cfg_deb_limit,
    input  logic [CH_NUM-1:0] cfg_rise_en,
    input  logic [CH_NUM-1:0] cfg_fall_en,
    input  logic [CH_NUM-1:0] irq_clr,
    output logic [CH_NUM-1:0] in_val,
    output logic [CH_NUM-1:0] irq_pend,
    output logic              irq
);

    localparam int                WARM_W    = warm_cnt_w(SYNC_STAGES);
    localparam logic [WARM_W-1:0] WARM_TERM = WARM_W'(SYNC_STAGES + 1);

    if (CH_NUM < 1 || CH_NUM > CH_MAX) begin : g_bad_ch_num
        $error("CH_NUM out of range 1..64");
    end
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("SYNC_STAGES out of range 2..4");
    end
    if (DEB_W < 1 || DEB_W > DEB_W_MAX) begin : g_bad_deb_w
        $error("DEB_W out of range 1..24");
    end

    logic [WARM_W-1:0] w;
    logic              warm;

    assign warm = (w == WARM_TERM);

    // Register the requested output value and enable toward the tristate buffers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pad_o_oval <= '0;
            pad_o_oe   <= '0;
        end else begin
            pad_o_oval <= cfg_out_val;
            pad_o_oe   <= cfg_out_en;
        end
    end

    // Count the cycles the synchronisers need to fill after reset, then hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w <= '0;
        end else if (w != WARM_TERM) begin
            w <= w + WARM_W'(1);
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
        e203_gpio_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_W       (DEB_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .warm      (warm),
            .pad       (pad_i_ival[i]),
            .deb_en    (cfg_deb_en[i]),
            .deb_limit (cfg_deb_limit),
            .rise_en   (cfg_rise_en[i]),
            .fall_en   (cfg_fall_en[i]),
            .irq_clr   (irq_clr[i]),
            .in_val    (in_val[i]),
            .irq_pend  (irq_pend[i])
        );
    end

    assign irq = |irq_pend;

endmodule
